mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter for the single 20-bit-address, 8-bit-data synchronous memory port. Port 0 serves the CPU core, port 1 serves a DMA/video fetcher. Each byte transfer runs through a fixed 4-cycle sequence. Port 1 has priority, and a starvation limit guarantees the core forward progress.

## Interface
- `STARVE_MAX`, default 4: consecutive port-1 grants allowed while port 0 is waiting; range 0–255.
- `clock`  in  1  — the block's one clock; rising-edge.
- `reset_n`  in  1  — asynchronous, active-low.
- `m0_req`, `m1_req`  in  1 each  — transfer request; master holds it until its ack.
- `m0_addr`, `m1_addr`  in  20 each  — byte address; stable while req is high.
- `m0_we`, `m1_we`  in  1 each  — 1 = write, 0 = read; stable while req is high.
- `m0_wdata`, `m1_wdata`  in  8 each  — write data; stable while req is high.
- `m0_ack`, `m1_ack`  out  1 each  — one-cycle completion pulse.
- `rdata`  out  8  — read data; valid while either ack is high.
- `mem_address`  out  20  — memory address.
- `mem_out`  out  8  — memory write data.
- `mem_wren`  out  1  — memory write enable.
- `mem_in`  in  8  — memory read data; valid the cycle after `mem_address` is presented.
- `grant`  out  2  — one-hot owner; bit 0 = port 0, bit 1 = port 1; 00 when idle.
- `busy`  out  1  — high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE. All outputs are registered.
- Transitions:
  - IDLE: if any req is high, choose a winner, latch its addr/we/wdata, go to ADDR. Otherwise stay in IDLE.
  - ADDR → DATA → DONE → IDLE unconditionally.
- Arbitration (IDLE only), using 8-bit saturating counter `starve`:
  - only m0_req → port 0.
  - only m1_req → port 1.
  - both, `starve >= STARVE_MAX` → port 0.
  - both, otherwise → port 1.
- `starve` updates at the arbitration edge:
  - +1 (saturating at 255) on a port-1 grant with m0_req high.
  - cleared on a port-0 grant.
  - cleared in IDLE whenever m0_req is low.
  - Consequence: `STARVE_MAX = 0` makes port 0 win every contention.
- ADDR:
  - `mem_address` = latched addr.
  - `mem_out` = latched wdata.
  - `mem_wren` = latched we. This is the only cycle `mem_wren` may be high.
- DATA: `mem_in` is captured into `rdata` at the end of the cycle. The capture happens for writes too, so `rdata` content after a write is don't-care.
- DONE: the granted port's ack = 1, `rdata` is held.
- `mem_address` and `mem_out` hold their last values outside ADDR. `rdata` holds until the next DATA capture.
- `grant` is set during ADDR, DATA and DONE, and is 00 in IDLE.
- A req withdrawn before the arbitration edge causes no transfer.
- A req dropped after its grant is a protocol violation. The transfer still completes and acks.
- The other master's req may stay high throughout. It is only evaluated in IDLE.

## Timing
- Reset values:
  - state = IDLE; `starve` = 0.
  - `m0_ack`, `m1_ack`, `mem_wren`, `busy` = 0; `grant` = 00.
  - `mem_address`, `mem_out`, `rdata` = 0.
- Reset asserted mid-transfer: outputs clear immediately (asynchronously), including `mem_wren` and any pending ack. No ack is issued for the aborted transfer.
- Latency, with req high in cycle 0 and FSM in IDLE:
  - cycle 1: ADDR (memory control).
  - cycle 2: DATA (`mem_in` valid).
  - cycle 3: DONE (ack + `rdata`).
  - cycle 4: IDLE, re-arbitration.
- Back-to-back: a master that keeps req high with new addr in cycle 4 gets ADDR in cycle 5. Peak throughput is 1 byte per 4 cycles.
- The FSM never samples req in DONE, so a still-high req is not double-served.
- Acks are mutually exclusive and never consecutive.

## Test plan
- **Single read:** m0 reads 0x12345, memory model returns 0xA5 one cycle after address.
  - `mem_address` = 0x12345 and `grant` = 01 in cycle 1; `mem_wren` = 0 throughout.
  - `m0_ack` = 1 only in cycle 3 with `rdata` = 0xA5; `m1_ack` never asserts.
- **Single write:** m1 writes 0x3C to 0xFFFFF.
  - `mem_wren` high exactly in cycle 1 with `mem_address` = 0xFFFFF and `mem_out` = 0x3C.
  - `m1_ack` in cycle 3; `grant` = 10 for cycles 1–3.
- **Starvation limit:** both masters request continuously with `STARVE_MAX` = 4.
  - Grant order is 1,1,1,1,0,1,1,1,1,0; acks every 4 cycles.
  - Repeat with `STARVE_MAX` = 0: grant order is 0,0,0… while m0_req stays high.
- **m0 alone, continuous:** m0 requests alone with addresses 0x00000, 0x00001, 0x00002, each changed after its ack.
  - `mem_address` steps in cycles 1, 5, 9; three acks; `starve` stays 0.
- **Reset during a write:** m1 write in flight, `reset_n` pulsed low during ADDR.
  - `mem_wren` falls without waiting for a clock edge; no ack issued; `busy` = 0.
  - After release, a new m0 read completes normally.
- **Withdrawn request:** m0_req high for half a cycle, dropped before the rising edge in IDLE.
  - No ADDR cycle, `busy` stays 0, no ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single 8-bit synchronous memory port.
// Port 1 has priority, and a starvation counter bounds how long port 0 can be held off.
module mem_arbiter #(
  parameter  int unsigned STARVE_MAX = 4,
  localparam int unsigned AW         = 20,
  localparam int unsigned DW         = 8,
  localparam int unsigned SW         = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_out,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_in,
  output logic [1:0]    grant,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [1:0]    grant_d;
  logic          busy_d, mem_wren_d, m0_ack_d, m1_ack_d;
  logic [AW-1:0] mem_address_d;
  logic [DW-1:0] mem_out_d, rdata_d;
  logic          pick_m0_c;

  // Port 0 wins when alone, or when it has waited through STARVE_MAX port-1 grants.
  assign pick_m0_c = m0_req && (!m1_req || (32'(starve_q) >= STARVE_MAX));

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    grant_d       = grant;
    busy_d        = busy;
    mem_address_d = mem_address;
    mem_out_d     = mem_out;
    mem_wren_d    = 1'b0;
    rdata_d       = rdata;
    m0_ack_d      = 1'b0;
    m1_ack_d      = 1'b0;

    case (state_q)
      IDLE: begin
        grant_d = 2'b00;
        busy_d  = 1'b0;
        if (!m0_req) begin
          starve_d = '0;
        end
        if (pick_m0_c) begin
          starve_d      = '0;
          grant_d       = 2'b01;
          busy_d        = 1'b1;
          mem_address_d = m0_addr;
          mem_out_d     = m0_wdata;
          mem_wren_d    = m0_we;
          state_d       = ADDR;
        end else if (m1_req) begin
          if (m0_req && (starve_q != {SW{1'b1}})) begin
            starve_d = starve_q + SW'(1);
          end
          grant_d       = 2'b10;
          busy_d        = 1'b1;
          mem_address_d = m1_addr;
          mem_out_d     = m1_wdata;
          mem_wren_d    = m1_we;
          state_d       = ADDR;
        end
      end
      ADDR: begin
        state_d = DATA;
      end
      DATA: begin
        // Memory read data is valid now; capture it so it is presented with the ack.
        rdata_d  = mem_in;
        m0_ack_d = grant[0];
        m1_ack_d = grant[1];
        state_d  = DONE;
      end
      DONE: begin
        grant_d = 2'b00;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        grant_d = 2'b00;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      grant       <= 2'b00;
      busy        <= 1'b0;
      mem_address <= '0;
      mem_out     <= '0;
      mem_wren    <= 1'b0;
      rdata       <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      grant       <= grant_d;
      busy        <= busy_d;
      mem_address <= mem_address_d;
      mem_out     <= mem_out_d;
      mem_wren    <= mem_wren_d;
      rdata       <= rdata_d;
      m0_ack      <= m0_ack_d;
      m1_ack      <= m1_ack_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected acks queued at request time, checked when acks appear.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [19:0] m0_addr = '0, m1_addr = '0;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic [7:0]  m0_wdata = '0, m1_wdata = '0;
  logic        m0_ack, m1_ack, mem_wren, busy;
  logic [7:0]  rdata, mem_out;
  logic [7:0]  mem_in = '0;
  logic [19:0] mem_address;
  logic [1:0]  grant;

  logic        z_m0_req = 1'b0, z_m1_req = 1'b0;
  logic        z_m0_ack, z_m1_ack, z_mem_wren, z_busy;
  logic [7:0]  z_rdata, z_mem_out;
  logic [7:0]  z_mem_in = '0;
  logic [19:0] z_mem_address;
  logic [1:0]  z_grant;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       port;
    logic       rd;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem [logic [19:0]];

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_we(m0_we), .m1_we(m1_we), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .rdata(rdata),
    .mem_address(mem_address), .mem_out(mem_out), .mem_wren(mem_wren), .mem_in(mem_in),
    .grant(grant), .busy(busy)
  );

  mem_arbiter #(.STARVE_MAX(0)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .m0_req(z_m0_req), .m1_req(z_m1_req), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_we(1'b0), .m1_we(1'b0), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_ack(z_m0_ack), .m1_ack(z_m1_ack), .rdata(z_rdata),
    .mem_address(z_mem_address), .mem_out(z_mem_out), .mem_wren(z_mem_wren), .mem_in(z_mem_in),
    .grant(z_grant), .busy(z_busy)
  );

  function automatic logic [7:0] mem_rd(input logic [19:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]};
  endfunction

  // Memory model: read data appears the cycle after the address.
  always @(posedge clock) begin
    if (mem_wren) mem[mem_address] = mem_out;
    mem_in   <= mem_rd(mem_address);
    z_mem_in <= mem_rd(z_mem_address);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Ack monitor: every ack must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset_n && (m0_ack || m1_ack)) begin
      check("ack_exclusive", 32'(m0_ack & m1_ack), 32'h0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(grant), 32'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_port", {30'h0, m1_ack, m0_ack}, e.port ? 32'h2 : 32'h1);
        if (e.rd) check("rdata", 32'(rdata), 32'(e.data));
      end
    end
  end

  // Waits for an ack on dut (sel=0) or dut0 (sel=1); n is the number of negedges waited.
  task automatic wait_ack(input logic sel, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if ((!sel && (m0_ack || m1_ack)) || (sel && (z_m0_ack || z_m1_ack))) begin
        n = i;
        return;
      end
    end
    check("ack_timeout", 32'h0, 32'h1);
  endtask

  task automatic xfer(input logic port, input logic [19:0] a, input logic we, input logic [7:0] wd);
    int n;
    exp_t e;
    e.port = port; e.rd = !we; e.data = mem_rd(a);
    if (port) begin m1_addr = a; m1_we = we; m1_wdata = wd; m1_req = 1'b1; end
    else      begin m0_addr = a; m0_we = we; m0_wdata = wd; m0_req = 1'b1; end
    sb.push_back(e);
    wait_ack(1'b0, n);
    check("xfer_latency", 32'(n), 32'd3);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int n;
    exp_t e;

    // Reset values
    #2;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_outs", {mem_address, mem_out, rdata}, 32'h0);
    check("rst_ctl", {29'h0, mem_wren, m0_ack, m1_ack}, 32'h0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Single read by m0
    mem[20'h12345] = 8'hA5;
    m0_addr = 20'h12345; m0_we = 1'b0; m0_req = 1'b1;
    e.port = 1'b0; e.rd = 1'b1; e.data = 8'hA5; sb.push_back(e);
    @(negedge clock);
    check("rd_c1_addr", 32'(mem_address), 32'h12345);
    check("rd_c1_grant", 32'(grant), 32'h1);
    check("rd_c1_wren", 32'(mem_wren), 32'h0);
    check("rd_c1_busy", 32'(busy), 32'h1);
    @(negedge clock);
    check("rd_c2_ack", {30'h0, m1_ack, m0_ack}, 32'h0);
    check("rd_c2_wren", 32'(mem_wren), 32'h0);
    @(negedge clock);
    check("rd_c3_ack", {30'h0, m1_ack, m0_ack}, 32'h1);
    m0_req = 1'b0;
    @(negedge clock);
    check("rd_c4_idle", {29'h0, busy, m0_ack, m1_ack}, 32'h0);
    check("rd_c4_grant", 32'(grant), 32'h0);

    // Single write by m1
    m1_addr = 20'hFFFFF; m1_we = 1'b1; m1_wdata = 8'h3C; m1_req = 1'b1;
    e.port = 1'b1; e.rd = 1'b0; e.data = 8'h00; sb.push_back(e);
    @(negedge clock);
    check("wr_c1_wren", 32'(mem_wren), 32'h1);
    check("wr_c1_addr", 32'(mem_address), 32'hFFFFF);
    check("wr_c1_data", 32'(mem_out), 32'h3C);
    check("wr_c1_grant", 32'(grant), 32'h2);
    @(negedge clock);
    check("wr_c2_wren", 32'(mem_wren), 32'h0);
    check("wr_c2_grant", 32'(grant), 32'h2);
    @(negedge clock);
    check("wr_c3_ack", {30'h0, m1_ack, m0_ack}, 32'h2);
    check("wr_c3_grant", 32'(grant), 32'h2);
    m1_req = 1'b0; m1_we = 1'b0;
    @(negedge clock);
    check("wr_mem", 32'(mem_rd(20'hFFFFF)), 32'h3C);

    // Contention with STARVE_MAX = 4: order 1,1,1,1,0 twice
    m0_addr = 20'h000A0; m1_addr = 20'h000B0; m0_we = 1'b0; m1_we = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      e.port = (k % 5) != 4; e.rd = 1'b1;
      e.data = e.port ? mem_rd(20'h000B0) : mem_rd(20'h000A0);
      sb.push_back(e);
    end
    for (int k = 0; k < 10; k++) begin
      wait_ack(1'b0, n);
      check("starve_interval", 32'(n), (k == 0) ? 32'd3 : 32'd4);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clock);

    // Contention with STARVE_MAX = 0: port 0 always wins
    z_m0_req = 1'b1; z_m1_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ack(1'b1, n);
      check("z_interval", 32'(n), (k == 0) ? 32'd3 : 32'd4);
      check("z_ack_port", {30'h0, z_m1_ack, z_m0_ack}, 32'h1);
    end
    z_m0_req = 1'b0; z_m1_req = 1'b0;
    @(negedge clock);

    // m0 alone, continuous, address changed after each ack
    m0_addr = 20'h00000; m0_we = 1'b0; m0_req = 1'b1;
    e.port = 1'b0; e.rd = 1'b1; e.data = mem_rd(20'h00000); sb.push_back(e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("seq_addr", 32'(mem_address), 32'(i));
      check("seq_grant", 32'(grant), 32'h1);
      @(negedge clock); @(negedge clock);
      check("seq_ack", 32'(m0_ack), 32'h1);
      check("seq_starve", 32'(dut.starve_q), 32'h0);
      if (i < 2) begin
        m0_addr = 20'(i + 1);
        e.data = mem_rd(m0_addr); sb.push_back(e);
        @(negedge clock);
        check("seq_idle", 32'(busy), 32'h0);
      end else begin
        m0_req = 1'b0;
      end
    end
    @(negedge clock);

    // Reset during an m1 write in ADDR
    m1_addr = 20'h55555; m1_we = 1'b1; m1_wdata = 8'h77; m1_req = 1'b1;
    @(negedge clock);
    check("rstw_wren_pre", 32'(mem_wren), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("rstw_wren", 32'(mem_wren), 32'h0);
    check("rstw_busy", 32'(busy), 32'h0);
    check("rstw_grant", 32'(grant), 32'h0);
    @(negedge clock); @(negedge clock);
    check("rstw_no_write", 32'(mem.exists(20'h55555)), 32'h0);
    reset_n = 1'b1; m1_req = 1'b0; m1_we = 1'b0;
    @(negedge clock);
    check("rstw_idle", 32'(busy), 32'h0);
    xfer(1'b0, 20'h00ABC, 1'b0, 8'h00);

    // Withdrawn request: high for half a cycle in IDLE
    m0_addr = 20'h0F0F0; m0_req = 1'b1;
    #2 m0_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("wd_busy", 32'(busy), 32'h0);
    end

    // Mixed back-to-back traffic from both ports
    xfer(1'b1, 20'hABCDE, 1'b0, 8'h00);
    xfer(1'b0, 20'h00777, 1'b1, 8'h5A);
    xfer(1'b0, 20'h00777, 1'b0, 8'h00);

    repeat (4) @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
